// File: rtl/waterlight_pkg.sv
// Shared mode codes, FSM state type and mode decode for the WaterLight LED sequencer.
package waterlight_pkg;

    localparam logic [7:0] MODE_LEFT  = 8'h01;
    localparam logic [7:0] MODE_RIGHT = 8'h02;
    localparam logic [7:0] MODE_FLASH = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2,
        ST_FLASH = 2'd3
    } state_t;

    function automatic state_t decode_mode(input logic [7:0] m);
        state_t s;
        unique case (m)
            MODE_LEFT:  s = ST_LEFT;
            MODE_RIGHT: s = ST_RIGHT;
            MODE_FLASH: s = ST_FLASH;
            default:    s = ST_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/waterlight_prescaler.sv
// Step-period counter: ticks every `speed` cycles while enabled; speed 0 freezes it at zero.
module waterlight_prescaler #(
    parameter int SPEED_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [SPEED_W-1:0] speed,
    output logic               tick
);

    logic [SPEED_W-1:0] cnt;
    logic               run;

    assign run = en && !clr && (speed != '0);

    // >= rather than == so a shrinking speed fires at once instead of wrapping
    assign tick = run && (cnt >= speed - SPEED_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + SPEED_W'(1);
        end
    end

endmodule

// File: rtl/waterlight_sequencer.sv
// LED pattern sequencer: rotates left/right or flashes the LED bank on prescaler ticks,
// restarting the selected pattern whenever the mode register changes.
module waterlight_sequencer
    import waterlight_pkg::*;
#(
    parameter int LED_W   = 8,
    parameter int SPEED_W = 32
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic [7:0]         mode,
    input  logic [SPEED_W-1:0] speed,
    output logic [LED_W-1:0]   LED,
    output logic               step,
    output logic               busy
);

    state_t           state, state_n;
    logic [7:0]       mode_q, mode_n;
    logic [LED_W-1:0] led_q, led_n;
    logic             step_q, step_n;
    logic             mode_chg;
    logic             tick;

    function automatic logic [LED_W-1:0] start_pat(input state_t s);
        logic [LED_W-1:0] p;
        unique case (s)
            ST_LEFT:  p = {{(LED_W-1){1'b0}}, 1'b1};
            ST_RIGHT: p = {1'b1, {(LED_W-1){1'b0}}};
            ST_FLASH: p = '1;
            default:  p = '0;
        endcase
        return p;
    endfunction

    assign mode_chg = (mode != mode_q);

    waterlight_prescaler #(
        .SPEED_W(SPEED_W)
    ) u_prescaler (
        .clk  (HCLK),
        .rst  (HRESET),
        .clr  (mode_chg),
        .en   (state != ST_IDLE),
        .speed(speed),
        .tick (tick)
    );

    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        led_n   = led_q;
        step_n  = 1'b0;
        // A mode change wins over any tick landing on the same edge
        if (mode_chg) begin
            mode_n  = mode;
            state_n = decode_mode(mode);
            led_n   = start_pat(decode_mode(mode));
        end else begin
            step_n = tick;
            unique case (state)
                ST_IDLE: begin
                    led_n  = '0;
                    step_n = 1'b0;
                end
                ST_LEFT: begin
                    if (tick) led_n = {led_q[LED_W-2:0], led_q[LED_W-1]};
                end
                ST_RIGHT: begin
                    if (tick) led_n = {led_q[0], led_q[LED_W-1:1]};
                end
                ST_FLASH: begin
                    if (tick) led_n = ~led_q;
                end
            endcase
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state  <= ST_IDLE;
            mode_q <= 8'h00;
            led_q  <= '0;
            step_q <= 1'b0;
        end else begin
            state  <= state_n;
            mode_q <= mode_n;
            led_q  <= led_n;
            step_q <= step_n;
        end
    end

    assign LED  = led_q;
    assign step = step_q;
    assign busy = (state != ST_IDLE);

endmodule
